// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer: time-multiplexed 3x3 valid-mode convolution over an external pixel memory
module conv3x3_sequencer #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              w_load,
    input  logic [3:0]        w_idx,
    input  logic [7:0]        w_data,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [7:0]        pix_data,
    output logic [23:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready
);
    typedef enum logic [2:0] {IDLE, READ, LAST, OUT, DONE} state_t;

    state_t            r_state;
    logic              r_busy, r_done, r_pix_rd, r_out_valid;
    logic [ADDR_W-1:0] r_pix_addr, r_out_addr, r_r, r_c;
    logic [23:0]       r_acc, r_out_data;
    logic [3:0]        r_k;
    logic [7:0]        r_w [9];

    logic [3:0]        w_sel;
    logic [15:0]       w_prod;
    logic              w_last, w_wrap;
    logic [ADDR_W-1:0] w_nr, w_nc;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [ADDR_W-1:0] i_r,
                                                 input logic [ADDR_W-1:0] i_c,
                                                 input logic [3:0] i_k);
        return ADDR_W'((32'(i_r) + 32'(i_k / 4'd3)) * 32'(IMG_W) + 32'(i_c) + 32'(i_k % 4'd3));
    endfunction

    // Pixel data lags its read by one cycle, so the weight used trails k by one; LAST consumes weight 8.
    assign w_sel  = (r_state == LAST) ? 4'd8 : (r_k == 4'd0 ? 4'd0 : r_k - 4'd1);
    assign w_prod = pix_data * r_w[w_sel];
    assign w_wrap = r_c == ADDR_W'(IMG_W - 3);
    assign w_last = w_wrap && r_r == ADDR_W'(IMG_H - 3);
    assign w_nc   = w_wrap ? '0 : r_c + ADDR_W'(1);
    assign w_nr   = w_wrap ? r_r + ADDR_W'(1) : r_r;

    assign busy      = r_busy;
    assign done      = r_done;
    assign pix_rd    = r_pix_rd;
    assign pix_addr  = r_pix_addr;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_valid = r_out_valid;

    // Control FSM: issues nine reads per window, accumulates, then holds the result until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix_rd    <= 1'b0;
            r_out_valid <= 1'b0;
            r_pix_addr  <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_acc       <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_k         <= '0;
            for (int i = 0; i < 9; i++) r_w[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load && w_idx < 4'd9) r_w[w_idx] <= w_data;
                    if (start) begin
                        r_state    <= READ;
                        r_busy     <= 1'b1;
                        r_acc      <= '0;
                        r_r        <= '0;
                        r_c        <= '0;
                        r_k        <= '0;
                        r_pix_rd   <= 1'b1;
                        r_pix_addr <= f_addr('0, '0, 4'd0);
                    end
                end
                READ: begin
                    if (r_k != 4'd0) r_acc <= r_acc + 24'(w_prod);
                    if (r_k == 4'd8) begin
                        r_state  <= LAST;
                        r_pix_rd <= 1'b0;
                    end else begin
                        r_k        <= r_k + 4'd1;
                        r_pix_addr <= f_addr(r_r, r_c, r_k + 4'd1);
                    end
                end
                LAST: begin
                    r_out_data  <= r_acc + 24'(w_prod);
                    r_out_addr  <= ADDR_W'(32'(r_r) * 32'(IMG_W - 2) + 32'(r_c));
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_r         <= w_nr;
                        r_c         <= w_nc;
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= READ;
                            r_k        <= '0;
                            r_pix_rd   <= 1'b1;
                            r_pix_addr <= f_addr(w_nr, w_nc, 4'd0);
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
